// File: rtl/mtsp_er1.sv
// mtsp_er1: arbitrates three GPR read requesters (SCs, LMB, PU) onto the
// single GPR read port. Grants follow fixed priority SCs > LMB > PU, except
// that a PU requester denied for long enough is boosted ahead of the others.
// Each grant issues one GPR read on the following cycle. A requester tag then
// travels alongside the read so the returned data is steered to the right
// VALID strobe, in grant order.
module mtsp_er1 #(
    parameter int GPR_AW = 6,
    parameter int RD_LAT = 2,
    parameter int STARVE = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              SCs_REQ,
    input  logic [GPR_AW-1:0] SCs_ADDR,
    input  logic              LMB_REQ,
    input  logic [GPR_AW-1:0] LMB_ADDR,
    input  logic              PU_REQ,
    input  logic [GPR_AW-1:0] PU_ADDR,
    output logic              SCs_ACK,
    output logic              LMB_ACK,
    output logic              PU_ACK,
    output logic              SCs_VALID,
    output logic              LMB_VALID,
    output logic              PU_VALID,
    output logic [127:0]      ER1_DATA,
    output logic              ER1_nEN,
    output logic [GPR_AW-1:0] ER1_ADDR,
    input  logic              GPR_BUSY,
    input  logic [127:0]      GPR_DATA
);

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_SCS  = 2'd1,
        TAG_LMB  = 2'd2,
        TAG_PU   = 2'd3
    } tag_t;

    localparam logic [3:0] BOOST_AT = 4'(STARVE - 1);

    logic [3:0]        pu_wait;
    logic              boost;
    tag_t              grant_tag;
    logic [GPR_AW-1:0] grant_addr;
    tag_t              issue_tag;
    tag_t              ret_tag [RD_LAT];

    assign boost = (pu_wait >= BOOST_AT);

    // Pick at most one requester; a boosted PU jumps the queue, busy or reset blocks all grants
    always_comb begin
        grant_tag  = TAG_NONE;
        grant_addr = '0;
        if (!RST && !GPR_BUSY) begin
            if (boost && PU_REQ) begin
                grant_tag  = TAG_PU;
                grant_addr = PU_ADDR;
            end else if (SCs_REQ) begin
                grant_tag  = TAG_SCS;
                grant_addr = SCs_ADDR;
            end else if (LMB_REQ) begin
                grant_tag  = TAG_LMB;
                grant_addr = LMB_ADDR;
            end else if (PU_REQ) begin
                grant_tag  = TAG_PU;
                grant_addr = PU_ADDR;
            end
        end
    end

    assign SCs_ACK = (grant_tag == TAG_SCS);
    assign LMB_ACK = (grant_tag == TAG_LMB);
    assign PU_ACK  = (grant_tag == TAG_PU);

    // Count cycles PU waits while the port is free; the count is frozen while the core owns the port
    always_ff @(posedge CLK) begin
        if (RST) begin
            pu_wait <= '0;
        end else if (GPR_BUSY) begin
            pu_wait <= pu_wait;
        end else if (!PU_REQ || PU_ACK) begin
            pu_wait <= '0;
        end else if (pu_wait != 4'hF) begin
            pu_wait <= pu_wait + 4'd1;
        end
    end

    // Issue the granted read one cycle after the grant; the address holds between reads
    always_ff @(posedge CLK) begin
        if (RST) begin
            ER1_nEN  <= 1'b1;
            ER1_ADDR <= '0;
        end else if (grant_tag != TAG_NONE) begin
            ER1_nEN  <= 1'b0;
            ER1_ADDR <= grant_addr;
        end else begin
            ER1_nEN  <= 1'b1;
        end
    end

    // Carry the requester tag alongside the read until its data arrives; reset drops all reads in flight
    always_ff @(posedge CLK) begin
        if (RST) begin
            issue_tag <= TAG_NONE;
            for (int i = 0; i < RD_LAT; i++) begin
                ret_tag[i] <= TAG_NONE;
            end
        end else begin
            issue_tag  <= grant_tag;
            ret_tag[0] <= issue_tag;
            for (int i = 1; i < RD_LAT; i++) begin
                ret_tag[i] <= ret_tag[i-1];
            end
        end
    end

    // Capture returning data and raise the owner's VALID for one cycle; data holds otherwise
    always_ff @(posedge CLK) begin
        if (RST) begin
            SCs_VALID <= 1'b0;
            LMB_VALID <= 1'b0;
            PU_VALID  <= 1'b0;
            ER1_DATA  <= '0;
        end else begin
            SCs_VALID <= (ret_tag[RD_LAT-1] == TAG_SCS);
            LMB_VALID <= (ret_tag[RD_LAT-1] == TAG_LMB);
            PU_VALID  <= (ret_tag[RD_LAT-1] == TAG_PU);
            if (ret_tag[RD_LAT-1] != TAG_NONE) begin
                ER1_DATA <= GPR_DATA;
            end
        end
    end

endmodule

// File: tb/tb_mtsp_er1.sv
// tb_mtsp_er1: directed vectors for the mtsp_er1 read arbiter. Expected
// returns are queued at grant time and popped by an independent monitor
// whenever any VALID is seen. Cycle-exact handshake checks sit inline.
module tb_mtsp_er1;

    localparam int GPR_AW = 6;
    localparam int RD_LAT = 2;
    localparam int STARVE = 4;

    localparam logic [2:0] W_SCS  = 3'b100;
    localparam logic [2:0] W_LMB  = 3'b010;
    localparam logic [2:0] W_PU   = 3'b001;
    localparam logic [2:0] W_NONE = 3'b000;

    logic              CLK = 1'b0;
    logic              RST;
    logic              SCs_REQ, LMB_REQ, PU_REQ;
    logic [GPR_AW-1:0] SCs_ADDR, LMB_ADDR, PU_ADDR;
    logic              SCs_ACK, LMB_ACK, PU_ACK;
    logic              SCs_VALID, LMB_VALID, PU_VALID;
    logic [127:0]      ER1_DATA;
    logic              ER1_nEN;
    logic [GPR_AW-1:0] ER1_ADDR;
    logic              GPR_BUSY;
    logic [127:0]      GPR_DATA;

    int n_vec  = 0;
    int n_err  = 0;
    int cyc_no = 0;
    int t0;

    typedef struct {
        logic [2:0]   who;
        logic [127:0] data;
        int           cyc;
    } exp_t;

    exp_t exp_q[$];

    logic [127:0] gpr_d [RD_LAT];
    logic         gpr_v [RD_LAT];

    mtsp_er1 #(.GPR_AW(GPR_AW), .RD_LAT(RD_LAT), .STARVE(STARVE)) dut (
        .CLK(CLK), .RST(RST),
        .SCs_REQ(SCs_REQ), .SCs_ADDR(SCs_ADDR),
        .LMB_REQ(LMB_REQ), .LMB_ADDR(LMB_ADDR),
        .PU_REQ(PU_REQ), .PU_ADDR(PU_ADDR),
        .SCs_ACK(SCs_ACK), .LMB_ACK(LMB_ACK), .PU_ACK(PU_ACK),
        .SCs_VALID(SCs_VALID), .LMB_VALID(LMB_VALID), .PU_VALID(PU_VALID),
        .ER1_DATA(ER1_DATA), .ER1_nEN(ER1_nEN), .ER1_ADDR(ER1_ADDR),
        .GPR_BUSY(GPR_BUSY), .GPR_DATA(GPR_DATA)
    );

    always #5 CLK = ~CLK;

    // Cycle counter used to timestamp expected returns
    always @(posedge CLK) cyc_no <= cyc_no + 1;

    // GPR content: address a holds byte {A, a[3:0]} repeated sixteen times
    function automatic logic [127:0] gpr_word(input logic [GPR_AW-1:0] a);
        return {16{4'hA, a[3:0]}};
    endfunction

    // GPR read port model: data appears RD_LAT cycles after an enabled read, poison otherwise
    always @(posedge CLK) begin
        gpr_v[0] <= !ER1_nEN;
        gpr_d[0] <= gpr_word(ER1_ADDR);
        for (int i = 1; i < RD_LAT; i++) begin
            gpr_v[i] <= gpr_v[i-1];
            gpr_d[i] <= gpr_d[i-1];
        end
    end

    assign GPR_DATA = (gpr_v[RD_LAT-1] === 1'b1) ? gpr_d[RD_LAT-1] : {4{32'hDEADBEEF}};

    // Monitor: every VALID must match the oldest queued expectation in owner, data and cycle
    always @(negedge CLK) begin
        logic [2:0] v;
        exp_t       e;
        v = {SCs_VALID, LMB_VALID, PU_VALID};
        if (v != W_NONE) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("[TB] FAIL unexpected_valid: got valid=%b at cycle %0d, expected none", v, cyc_no);
            end else begin
                e = exp_q.pop_front();
                if (v !== e.who || ER1_DATA !== e.data || cyc_no != e.cyc) begin
                    n_err++;
                    $display("[TB] FAIL return: got valid=%b data=%0h cycle=%0d, expected valid=%b data=%0h cycle=%0d",
                             v, ER1_DATA, cyc_no, e.who, e.data, e.cyc);
                end
            end
        end
    end

    task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    task automatic apply_stimulus(input logic [2:0] req, input logic [GPR_AW-1:0] a_s,
                                  input logic [GPR_AW-1:0] a_l, input logic [GPR_AW-1:0] a_p,
                                  input logic busy, input logic rst);
        @(posedge CLK);
        #1;
        {SCs_REQ, LMB_REQ, PU_REQ} = req;
        SCs_ADDR = a_s;
        LMB_ADDR = a_l;
        PU_ADDR  = a_p;
        GPR_BUSY = busy;
        RST      = rst;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(W_NONE, '0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic push_exp(input logic [2:0] who, input logic [127:0] data, input int cyc);
        exp_t e;
        e.who  = who;
        e.data = data;
        e.cyc  = cyc;
        exp_q.push_back(e);
    endtask

    function automatic logic [2:0] acks();
        return {SCs_ACK, LMB_ACK, PU_ACK};
    endfunction

    function automatic logic [2:0] valids();
        return {SCs_VALID, LMB_VALID, PU_VALID};
    endfunction

    initial begin
        RST = 1'b1; GPR_BUSY = 1'b0;
        SCs_REQ = 1'b0; LMB_REQ = 1'b0; PU_REQ = 1'b0;
        SCs_ADDR = '0; LMB_ADDR = '0; PU_ADDR = '0;

        // Reset state, with a request pending to prove reset blocks grants
        apply_stimulus(W_SCS, 6'd1, '0, '0, 1'b0, 1'b1);
        @(negedge CLK);
        check_output("reset_ack", acks(), W_NONE);
        check_output("reset_valid", valids(), W_NONE);
        check_output("reset_nen", ER1_nEN, 1'b1);
        check_output("reset_addr", ER1_ADDR, 0);
        check_output("reset_data", ER1_DATA, 0);
        check_output("reset_pu_wait", dut.pu_wait, 0);
        idle(2);

        // Single LMB read of address 5
        apply_stimulus(W_LMB, '0, 6'd5, '0, 1'b0, 1'b0);
        t0 = cyc_no;
        @(negedge CLK);
        check_output("single_ack", acks(), W_LMB);
        push_exp(W_LMB, {16{8'hA5}}, t0 + 4);
        apply_stimulus(W_NONE, '0, 6'd5, '0, 1'b0, 1'b0);
        @(negedge CLK);
        check_output("single_nen_c1", ER1_nEN, 1'b0);
        check_output("single_addr_c1", ER1_ADDR, 5);
        check_output("single_ack_c1", acks(), W_NONE);
        apply_stimulus(W_NONE, '0, '0, '0, 1'b0, 1'b0);
        @(negedge CLK);
        check_output("single_nen_c2", ER1_nEN, 1'b1);
        check_output("single_addr_hold", ER1_ADDR, 5);
        idle(5);

        // All three request at once: served SCs, LMB, PU on consecutive cycles
        apply_stimulus(3'b111, 6'd1, 6'd2, 6'd3, 1'b0, 1'b0);
        t0 = cyc_no;
        @(negedge CLK);
        check_output("prio_ack_c0", acks(), W_SCS);
        push_exp(W_SCS, {16{8'hA1}}, t0 + 4);
        push_exp(W_LMB, {16{8'hA2}}, t0 + 5);
        push_exp(W_PU,  {16{8'hA3}}, t0 + 6);
        apply_stimulus(3'b011, 6'd1, 6'd2, 6'd3, 1'b0, 1'b0);
        @(negedge CLK);
        check_output("prio_ack_c1", acks(), W_LMB);
        check_output("prio_addr_c1", ER1_ADDR, 1);
        apply_stimulus(3'b001, 6'd1, 6'd2, 6'd3, 1'b0, 1'b0);
        @(negedge CLK);
        check_output("prio_ack_c2", acks(), W_PU);
        check_output("prio_addr_c2", ER1_ADDR, 2);
        check_output("prio_pu_wait_c2", dut.pu_wait, 2);
        apply_stimulus(W_NONE, '0, '0, '0, 1'b0, 1'b0);
        @(negedge CLK);
        check_output("prio_addr_c3", ER1_ADDR, 3);
        check_output("prio_nen_c3", ER1_nEN, 1'b0);
        idle(5);

        // Starvation: SCs holds the port until PU is boosted on the fourth cycle
        apply_stimulus(3'b101, 6'd10, '0, 6'd13, 1'b0, 1'b0);
        t0 = cyc_no;
        @(negedge CLK);
        check_output("starve_ack_c0", acks(), W_SCS);
        push_exp(W_SCS, {16{8'hAA}}, t0 + 4);
        apply_stimulus(3'b101, 6'd11, '0, 6'd13, 1'b0, 1'b0);
        @(negedge CLK);
        check_output("starve_ack_c1", acks(), W_SCS);
        push_exp(W_SCS, {16{8'hAB}}, t0 + 5);
        apply_stimulus(3'b101, 6'd12, '0, 6'd13, 1'b0, 1'b0);
        @(negedge CLK);
        check_output("starve_ack_c2", acks(), W_SCS);
        push_exp(W_SCS, {16{8'hAC}}, t0 + 6);
        apply_stimulus(3'b101, 6'd14, '0, 6'd13, 1'b0, 1'b0);
        @(negedge CLK);
        check_output("starve_pu_wait_c3", dut.pu_wait, 3);
        check_output("starve_ack_c3", acks(), W_PU);
        push_exp(W_PU, {16{8'hAD}}, t0 + 7);
        apply_stimulus(W_SCS, 6'd14, '0, '0, 1'b0, 1'b0);
        @(negedge CLK);
        check_output("starve_pu_wait_c4", dut.pu_wait, 0);
        check_output("starve_ack_c4", acks(), W_SCS);
        push_exp(W_SCS, {16{8'hAE}}, t0 + 8);
        idle(7);

        // Busy: no grants for three cycles, PU wait count frozen, then LMB then PU
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(3'b011, '0, 6'd6, 6'd7, 1'b1, 1'b0);
            if (i == 0) t0 = cyc_no;
            @(negedge CLK);
            check_output("busy_ack", acks(), W_NONE);
            check_output("busy_pu_wait", dut.pu_wait, 0);
        end
        apply_stimulus(3'b011, '0, 6'd6, 6'd7, 1'b0, 1'b0);
        @(negedge CLK);
        check_output("busy_ack_c3", acks(), W_LMB);
        check_output("busy_pu_wait_c3", dut.pu_wait, 0);
        push_exp(W_LMB, {16{8'hA6}}, t0 + 7);
        apply_stimulus(W_PU, '0, '0, 6'd7, 1'b0, 1'b0);
        @(negedge CLK);
        check_output("busy_ack_c4", acks(), W_PU);
        check_output("busy_pu_wait_c4", dut.pu_wait, 1);
        push_exp(W_PU, {16{8'hA7}}, t0 + 8);
        idle(7);

        // Reset mid-flight: the SCs read is dropped, a grant right after reset still works
        apply_stimulus(W_SCS, 6'd9, '0, '0, 1'b0, 1'b0);
        t0 = cyc_no;
        @(negedge CLK);
        check_output("rstmid_ack_c0", acks(), W_SCS);
        apply_stimulus(W_NONE, '0, '0, '0, 1'b0, 1'b0);
        apply_stimulus(W_SCS, 6'd9, '0, '0, 1'b0, 1'b1);
        @(negedge CLK);
        check_output("rstmid_ack_in_reset", acks(), W_NONE);
        apply_stimulus(W_LMB, '0, 6'd4, '0, 1'b0, 1'b0);
        @(negedge CLK);
        check_output("rstmid_data_cleared", ER1_DATA, 0);
        check_output("rstmid_addr_cleared", ER1_ADDR, 0);
        check_output("rstmid_nen", ER1_nEN, 1'b1);
        check_output("rstmid_first_ack", acks(), W_LMB);
        check_output("rstmid_valid_c3", valids(), W_NONE);
        push_exp(W_LMB, {16{8'hA4}}, t0 + 7);
        for (int c = 4; c <= 6; c++) begin
            apply_stimulus(W_NONE, '0, '0, '0, 1'b0, 1'b0);
            @(negedge CLK);
            check_output("rstmid_no_valid", valids(), W_NONE);
        end
        idle(5);

        // Streaming: eight back-to-back LMB reads of addresses 0..7
        for (int k = 0; k < 8; k++) begin
            apply_stimulus(W_LMB, '0, 6'(k), '0, 1'b0, 1'b0);
            if (k == 0) t0 = cyc_no;
            @(negedge CLK);
            check_output("stream_ack", acks(), W_LMB);
            if (k > 0) begin
                check_output("stream_addr", ER1_ADDR, 128'(k - 1));
                check_output("stream_nen", ER1_nEN, 1'b0);
            end
            push_exp(W_LMB, {16{4'hA, 4'(k)}}, t0 + 4 + k);
        end
        apply_stimulus(W_NONE, '0, '0, '0, 1'b0, 1'b0);
        @(negedge CLK);
        check_output("stream_addr_last", ER1_ADDR, 7);
        idle(10);

        @(negedge CLK);
        check_output("queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mtsp_er1.md
MTSP_ER1 -- requirements
Module: MTSP_ER1

Interface
REQ-001 SHALL have parameter GPR_AW, default 6, meaning the GPR address width.
REQ-002 SHALL have parameter RD_LAT, default 2, meaning the cycles from GPR read issue to GPR_DATA valid; legal range 1..4.
REQ-003 SHALL have parameter STARVE, default 4, meaning the consecutive denied cycles after which PU is boosted; legal range 2..15.
REQ-004 SHALL have port CLK  in  1  main clock; all logic on the rising edge.
REQ-005 SHALL have port RST  in  1  reset, synchronous and active-high.
REQ-006 SHALL have ports SCs_REQ  in  1 and SCs_ADDR  in  GPR_AW: scratch-counter read request and its GPR address.
REQ-007 SHALL have ports LMB_REQ  in  1 and LMB_ADDR  in  GPR_AW: local-memory-block store read request and its GPR address.
REQ-008 SHALL have ports PU_REQ  in  1 and PU_ADDR  in  GPR_AW: pack/unpack read request and its GPR address.
REQ-009 SHALL have ports SCs_ACK, LMB_ACK, PU_ACK  out  1 each: request granted this cycle (combinational).
REQ-010 SHALL have ports SCs_VALID, LMB_VALID, PU_VALID  out  1 each: read data returned this cycle (registered).
REQ-011 SHALL have port ER1_DATA  out  128  returned data, shared by the three requesters.
REQ-012 SHALL have port ER1_nEN  out  1  GPR read enable, active low, registered.
REQ-013 SHALL have port ER1_ADDR  out  GPR_AW  GPR read address, registered.
REQ-014 SHALL have port GPR_BUSY  in  1  core owns the GPR read port this cycle; the block issues no grant while it is high.
REQ-015 SHALL have port GPR_DATA  in  128  GPR read data, valid RD_LAT cycles after the read is issued.

Function
REQ-016 SHALL assert at most one ACK per cycle, and only when GPR_BUSY=0 and RST=0.
REQ-017 SHALL grant in fixed priority SCs > LMB > PU when no boost is active.
REQ-018 SHALL, when the boost is active and PU_REQ=1, grant PU ahead of SCs and LMB.
REQ-019 SHALL operate the PU wait counter as follows:
- Increments when PU_REQ=1, PU_ACK=0 and GPR_BUSY=0.
- Clears on PU_ACK or when PU_REQ=0.
- Holds while GPR_BUSY=1.
- Boost is active when the counter is greater than or equal to STARVE-1.
REQ-020 SHALL follow the request handshake: a requester holds REQ and ADDR stable until it sees ACK; the transfer completes in the ACK cycle; REQ may stay high in the next cycle for a new read.
REQ-021 SHALL, on a grant in cycle t, drive ER1_nEN=0 and ER1_ADDR=granted ADDR in cycle t+1; in all other cycles ER1_nEN=1 and ER1_ADDR holds its value.
REQ-022 SHALL carry a 2-bit tag (none/SCs/LMB/PU) through a pipeline of RD_LAT stages after issue.
REQ-023 SHALL sample GPR_DATA in cycle t+1+RD_LAT into ER1_DATA, and assert the tagged requester's VALID for exactly one cycle, t+2+RD_LAT.
REQ-024 SHALL hold ER1_DATA at its last value when no VALID is asserted.
REQ-025 SHALL assert at most one VALID per cycle.
REQ-026 SHALL return data in grant order.
REQ-027 SHALL sustain one grant per cycle back-to-back, with no bubbles.
REQ-028 SHALL accept a GPR_BUSY rising edge with reads in flight: in-flight reads complete normally; only new grants are blocked.
REQ-029 SHALL handle simultaneous SCs/LMB/PU requests by serving them in consecutive cycles in priority order, subject to the boost.

Reset
REQ-030 SHALL, while RST=1, drive all ACK=0, all VALID=0, ER1_nEN=1, ER1_ADDR=0 and ER1_DATA=0, clear the PU wait counter, and clear all pipeline tags.
REQ-031 SHALL, on a reset asserted mid-operation, discard outstanding reads so that no VALID is asserted after RST deasserts for any read granted before reset.
REQ-032 SHALL allow the first grant in the cycle after RST deasserts.

Verification
REQ-033 SHALL cover single read: RD_LAT=2, LMB_REQ=1, LMB_ADDR=5 in cycle 0 -> LMB_ACK in cycle 0; ER1_nEN=0, ER1_ADDR=5 in cycle 1; GPR_DATA=0xA5..A5 in cycle 3; LMB_VALID=1, ER1_DATA=0xA5..A5 in cycle 4 only.
REQ-034 SHALL cover priority: SCs, LMB and PU all requesting in cycle 0 with addresses 1/2/3 -> ACKs SCs, LMB, PU in cycles 0, 1, 2; ER1_ADDR 1, 2, 3 in cycles 1, 2, 3; VALIDs SCs, LMB, PU in cycles 4, 5, 6.
REQ-035 SHALL cover starvation: STARVE=4, SCs_REQ and PU_REQ held high -> SCs granted cycles 0-2 and PU granted in cycle 3; the PU wait counter is 0 in cycle 4.
REQ-036 SHALL cover busy: GPR_BUSY=1 in cycles 0-2 with LMB_REQ=1 -> no ACK in cycles 0-2; LMB_ACK in cycle 3; the PU counter does not move during the busy cycles.
REQ-037 SHALL cover reset mid-flight: grant in cycle 0 and RST=1 in cycle 2 -> no VALID in cycles 3-6; ER1_DATA=0.
REQ-038 SHALL cover streaming: 8 back-to-back LMB reads of addresses 0-7 -> 8 consecutive LMB_VALID cycles with data in address order.
